// File: rtl/alu_muldiv_sequencer.sv
// rtl/alu_muldiv_sequencer.sv - multi-cycle MUL/DIVU/REMU sequencer driving a shared ALU
module alu_muldiv_sequencer #(
   parameter  int DATA_WIDTH = 32,
   localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [DATA_WIDTH-1:0] alu_op1,
   output logic [DATA_WIDTH-1:0] alu_op2,
   output logic [4:0]            alu_ctrl,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic                  alu_zero
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MUL_STEP = 3'd1,
      S_DIV_CMP  = 3'd2,
      S_DIV_SUB  = 3'd3,
      S_DONE     = 3'd4
   } state_e;

   localparam logic [4:0]       CTRL_ADD  = 5'b00000;
   localparam logic [4:0]       CTRL_SUB  = 5'b00001;
   localparam logic [4:0]       CTRL_SLTU = 5'b01111;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);

   state_e                  state_q;
   logic [1:0]              op_q;
   logic [DATA_WIDTH-1:0]   b_q;
   logic [DATA_WIDTH-1:0]   acc_q;
   logic [DATA_WIDTH-1:0]   mcand_q;
   logic [DATA_WIDTH-1:0]   mplier_q;
   logic [DATA_WIDTH-1:0]   rem_q;
   logic [DATA_WIDTH-1:0]   quo_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    take_q;
   logic [DATA_WIDTH-1:0]   result_q;
   logic                    done_q;

   // Partial remainder with the next dividend bit shifted in; the bit shifted
   // out of the top is kept separately because it forces a subtraction.
   logic [DATA_WIDTH-1:0]   rem_sh_d;
   logic                    rem_msb_d;

   assign rem_sh_d  = {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
   assign rem_msb_d = rem_q[DATA_WIDTH-1];

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;

   // ALU drive: one operation per active state, quiet (add 0+0) otherwise
   always_comb begin
      alu_ctrl = CTRL_ADD;
      alu_op1  = '0;
      alu_op2  = '0;
      case (state_q)
         S_MUL_STEP: begin
            alu_ctrl = CTRL_ADD;
            alu_op1  = acc_q;
            alu_op2  = mcand_q;
         end
         S_DIV_CMP: begin
            alu_ctrl = CTRL_SLTU;
            alu_op1  = rem_sh_d;
            alu_op2  = b_q;
         end
         S_DIV_SUB: begin
            alu_ctrl = CTRL_SUB;
            alu_op1  = rem_sh_d;
            alu_op2  = b_q;
         end
         default: begin
            alu_ctrl = CTRL_ADD;
            alu_op1  = '0;
            alu_op2  = '0;
         end
      endcase
   end

   // Sequencer FSM with its datapath registers and registered done/result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         take_q   <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  b_q   <= b;
                  cnt_q <= '0;
                  if (!op[1]) begin
                     // op 01 is reserved and runs as MUL
                     acc_q    <= '0;
                     mcand_q  <= a;
                     mplier_q <= b;
                     state_q  <= S_MUL_STEP;
                  end else if (b != '0) begin
                     rem_q   <= '0;
                     quo_q   <= a;
                     state_q <= S_DIV_CMP;
                  end else begin
                     // Divide by zero: quotient all-ones, remainder is the dividend
                     quo_q   <= '1;
                     rem_q   <= a;
                     state_q <= S_DONE;
                  end
               end
            end
            S_MUL_STEP: begin
               if (mplier_q[0]) begin
                  acc_q <= alu_out;
               end
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
               end
            end
            S_DIV_CMP: begin
               // alu_zero is set when rem_sh < b, so a subtraction fits when it is clear
               take_q  <= rem_msb_d | ~alu_zero;
               state_q <= S_DIV_SUB;
            end
            S_DIV_SUB: begin
               rem_q <= take_q ? alu_out : rem_sh_d;
               quo_q <= {quo_q[DATA_WIDTH-2:0], take_q};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
               end else begin
                  state_q <= S_DIV_CMP;
               end
            end
            S_DONE: begin
               done_q <= 1'b1;
               if (op_q[1]) begin
                  result_q <= op_q[0] ? rem_q : quo_q;
               end else begin
                  result_q <= acc_q;
               end
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb/tb_alu_muldiv_sequencer.sv - scoreboard bench for alu_muldiv_sequencer
module tb_alu_muldiv_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [4:0]  alu_ctrl;
   logic [31:0] alu_out;
   logic        alu_zero;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          t0;
   } exp_t;

   exp_t q[$];
   int   tests;
   int   fails;
   int   cyc;

   alu_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .alu_op1  (alu_op1),
      .alu_op2  (alu_op2),
      .alu_ctrl (alu_ctrl),
      .alu_out  (alu_out),
      .alu_zero (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Shared ALU model: add, sub, unsigned less-than (zero flag = op1 < op2)
   always_comb begin
      alu_out  = 32'd0;
      alu_zero = 1'b0;
      case (alu_ctrl)
         5'b00000: begin
            alu_out  = alu_op1 + alu_op2;
            alu_zero = (alu_out == 32'd0);
         end
         5'b00001: begin
            alu_out  = alu_op1 - alu_op2;
            alu_zero = (alu_out == 32'd0);
         end
         5'b01111: begin
            alu_out  = {31'd0, alu_op1 < alu_op2};
            alu_zero = (alu_op1 < alu_op2);
         end
         default: begin
            alu_out  = 32'd0;
            alu_zero = 1'b0;
         end
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no done (result 0x%08h)", result);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", result, e.res);
            check("latency", 32'(cyc - e.t0), 32'(e.lat));
         end
      end
   end

   // Issue one operation (entered and left at a negedge); poke>0 pulses a
   // conflicting start that many cycles into the operation.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input int lat, input int poke);
      exp_t e;
      int   n;
      bit   busy_ok;
      bit   ctrl_ok;
      logic [4:0] exp_ctrl;
      e.res = r;
      e.lat = lat;
      e.t0  = cyc + 1;
      q.push_back(e);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0000_0003;
      n       = 0;
      busy_ok = 1'b1;
      ctrl_ok = 1'b1;
      while (!done && n < 200) begin
         if (!busy) busy_ok = 1'b0;
         if (lat == 65)      exp_ctrl = (n < 64) ? ((n % 2 == 0) ? 5'b01111 : 5'b00001) : 5'b00000;
         else                exp_ctrl = 5'b00000;
         if (alu_ctrl !== exp_ctrl) ctrl_ok = 1'b0;
         if (lat == 1 && (alu_op1 !== 32'd0 || alu_op2 !== 32'd0)) ctrl_ok = 1'b0;
         if (poke > 0 && n == poke) begin
            start = 1'b1;
            op    = 2'b10;
            b     = 32'd0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("done_seen", {31'd0, done}, 32'd1);
      check("busy_while_running", {31'd0, busy_ok}, 32'd1);
      check("alu_drive_sequence", {31'd0, ctrl_ok}, 32'd1);
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
      check("alu_idle_at_done", {27'd0, alu_ctrl} | alu_op1 | alu_op2, 32'd0);
   endtask

   initial begin
      bit seen;
      tests = 0;
      fails = 0;
      cyc   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_alu_ctrl", {27'd0, alu_ctrl}, 32'd0);
      check("rst_alu_op1", alu_op1, 32'd0);
      check("rst_alu_op2", alu_op2, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(2'b00, 32'd7,          32'd6,          32'd42,         33, 0);
      run_op(2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  33, 0);
      run_op(2'b00, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000,  33, 0);
      run_op(2'b01, 32'd3,          32'd4,          32'd12,         33, 0);
      run_op(2'b10, 32'd100,        32'd7,          32'd14,         65, 0);
      run_op(2'b11, 32'd100,        32'd7,          32'd2,          65, 0);
      run_op(2'b10, 32'hFFFF_FFFF,  32'h8000_0001,  32'h0000_0001,  65, 0);
      run_op(2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  65, 0);
      run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  65, 0);
      run_op(2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  65, 0);
      run_op(2'b10, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0);
      run_op(2'b11, 32'd5,          32'd0,          32'd5,          1,  0);
      run_op(2'b00, 32'd7,          32'd6,          32'd42,         33, 5);

      // Abandon a MUL with reset mid-way: no done, result cleared
      start = 1'b1;
      op    = 2'b00;
      a     = 32'd3;
      b     = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("no_done_after_reset", {31'd0, seen}, 32'd0);

      run_op(2'b10, 32'd9, 32'd3, 32'd3, 65, 0);

      repeat (3) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL pending_expectations: got %0d left expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
